// File: rtl/cache_types.sv
// Shared types and default widths for the L1-to-L2 memory arbiter slice.
package cache_types;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

    // Index width that stays legal for a single-channel build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating picker: first requester at or after 'start', wrapping to 0.
import cache_types::*;

module rr_pick #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  grant_idx
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk the channels in priority order starting at 'start'; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, start} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_CH)) begin
                sum = sum - (IDX_W+1)'(NUM_CH);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates NUM_CH L1 line read/writeback requests onto a single L2 port.
// Define ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
import cache_types::*;

module mem_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              ch_read,
    input  logic [NUM_CH-1:0]              ch_write,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_addr,
    input  logic [NUM_CH-1:0][LINE_W-1:0]  ch_wdata,
    output logic [LINE_W-1:0]              ch_rdata,
    output logic [NUM_CH-1:0]              ch_resp,
    output logic                           L2_read,
    output logic                           L2_write,
    output logic [ADDR_W-1:0]              L2_addr,
    output logic [LINE_W-1:0]              L2_wdata,
    input  logic [LINE_W-1:0]              L2_rdata,
    input  logic                           L2_resp
);

    localparam int IDX_W = idx_width(NUM_CH);

    arb_state_t        state, next_state;
    logic [NUM_CH-1:0] req_vec;
    logic [IDX_W-1:0]  pick_start;
    logic [IDX_W-1:0]  pick_idx;
    logic [NUM_CH-1:0] pick_oh;
    logic              take_grant;

    logic [NUM_CH-1:0] grant_oh;
    logic [ADDR_W-1:0] lat_addr;
    logic [LINE_W-1:0] lat_wdata;
    logic              lat_write;

    assign req_vec = ch_read | ch_write;

`ifdef ARB_FIXED_PRIO_EN
    assign pick_start = '0;
`else
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] next_ptr;

    // The pointer advances only when a transaction completes, so an aborted grant does not rotate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_idx <= '0;
            next_ptr  <= '0;
        end else begin
            if (take_grant) begin
                grant_idx <= pick_idx;
            end
            if (state == BUSY && L2_resp) begin
                next_ptr <= (grant_idx == IDX_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign pick_start = next_ptr;
`endif

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req       (req_vec),
        .start     (pick_start),
        .grant     (pick_oh),
        .grant_idx (pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request fields are captured once at grant so L2 sees stable values even if the requester drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_oh  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
        end else if (take_grant) begin
            grant_oh  <= pick_oh;
            lat_addr  <= ch_addr[pick_idx];
            lat_wdata <= ch_wdata[pick_idx];
            lat_write <= ch_write[pick_idx];
        end
    end

    always_comb begin
        next_state = state;
        take_grant = 1'b0;
        L2_read    = 1'b0;
        L2_write   = 1'b0;
        L2_addr    = '0;
        L2_wdata   = '0;
        ch_resp    = '0;
        ch_rdata   = '0;
        case (state)
            IDLE: begin
                if (|req_vec) begin
                    take_grant = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                L2_read  = !lat_write;
                L2_write = lat_write;
                L2_addr  = lat_addr;
                L2_wdata = lat_wdata;
                if (L2_resp) begin
                    ch_resp    = grant_oh;
                    ch_rdata   = L2_rdata;
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2, number of L1 requester channels (2..8).
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Parameter LINE_W, default 128, cache-line width in bits.
REQ-004 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port ch_read  input  NUM_CH  per-channel line-read request, held until that channel's ch_resp.
REQ-007 Port ch_write  input  NUM_CH  per-channel line-write (writeback) request, held until that channel's ch_resp.
REQ-008 Port ch_addr  input  NUM_CH x ADDR_W  per-channel line address.
REQ-009 Port ch_wdata  input  NUM_CH x LINE_W  per-channel writeback data.
REQ-010 Port ch_rdata  output  LINE_W  read data, shared by all channels; valid only with a ch_resp bit.
REQ-011 Port ch_resp  output  NUM_CH  one-hot completion pulse to the granted channel.
REQ-012 Ports L2_read, L2_write  output  1 each  request to L2 / physical memory.
REQ-013 Port L2_addr  output  ADDR_W; port L2_wdata  output  LINE_W.
REQ-014 Port L2_rdata  input  LINE_W; port L2_resp  input  1  L2 completion.

Function
REQ-015 FSM states: IDLE, BUSY, DONE.
REQ-016 IDLE: if any channel requests, at the clock edge select a winner, latch its index, addr, wdata and op (write over read), and go to BUSY; otherwise stay in IDLE.
REQ-017 Winner: round-robin; search starts at the channel after the last granted channel and wraps from NUM_CH-1 to 0; after reset the search starts at channel 0.
REQ-018 BUSY: assert L2_read or L2_write per the latched op; drive L2_addr and L2_wdata from the latched values; hold them stable until L2_resp.
REQ-019 On L2_resp in BUSY, assert ch_resp[grant] in the same cycle, drive ch_rdata = L2_rdata combinationally, update the last-granted pointer, and go to DONE.
REQ-020 DONE: one cycle with no L2 request and ch_resp all zero, so the requester can deassert; then go to IDLE.
REQ-021 Minimum request-to-L2 latency: 1 cycle.
REQ-022 Turnaround from one L2_resp to the next L2 request: 3 cycles.
REQ-023 If the granted channel drops its request in BUSY, the L2 transaction still completes and ch_resp is still pulsed.
REQ-024 If a channel asserts ch_read and ch_write together, the write is serviced and the read is ignored for that grant.
REQ-025 Non-granted channels are never responded to. Their requests stay pending without loss.
REQ-026 ch_rdata drives 0 when no ch_resp bit is set.
REQ-027 L2_resp in IDLE or DONE is ignored.

Reset
REQ-028 rst forces IDLE immediately. L2_read, L2_write and ch_resp go to 0 and L2_addr/L2_wdata go to 0 without waiting for clk.
REQ-029 rst also clears the last-granted pointer (next search starts at channel 0). Reset during BUSY abandons the transaction with no ch_resp pulse.

Configuration
REQ-030 Macro ARB_FIXED_PRIO_EN: when defined, the winner is the lowest-numbered requesting channel and the pointer is unused. When undefined, the round-robin of REQ-017 applies.

Structure
REQ-031 Package cache_types holds the arb_state_t enum (IDLE, BUSY, DONE) and the default LINE_W/ADDR_W constants.
REQ-032 One sub-module, rr_pick, is combinational: its inputs are the request vector and the start pointer, and its outputs are a one-hot grant and an index.

Verification
REQ-033 NUM_CH=2, ch_read=01, addr 0x1230, L2_resp after 3 BUSY cycles with rdata=0xA5.. -> L2_read=1 and L2_addr=0x1230 from cycle 1; ch_resp=01 with ch_rdata=0xA5.. in the L2_resp cycle; DONE in the next cycle.
REQ-034 Both channels hold ch_read continuously for 4 transactions -> grant order is 0,1,0,1.
REQ-035 Same as REQ-034 with ARB_FIXED_PRIO_EN defined -> grant order is 0,0,0,0 and channel 1 is never served while channel 0 requests.
REQ-036 Channel 1 ch_write, addr 0x4000, wdata 0xDEAD.. -> L2_write=1 with L2_addr=0x4000 and L2_wdata=0xDEAD..; ch_resp=10.
REQ-037 rst pulsed mid-BUSY -> L2_read drops within the reset pulse with no clock edge; no ch_resp; the next grant after reset goes to channel 0.
REQ-038 NUM_CH=4, requests on channels 3 and 0 after the last grant to 3 -> channel 0 wins (wrap-around).
